ps2_scancode_rx: RTL
====================

// Module: ps2_scancode_rx
// PURPOSE
// - PS/2 keyboard receiver; sits between the raw PS2_CLK/PS2_DAT pins and the direction decoder.
// - Syncs pins into clk domain, deframes 11-bit frames, checks start/parity/stop.
// - Folds E0 (extended) and F0 (break) prefixes into one qualified scan-code event.
// - Emits scan codes as single-cycle valid pulses; optionally tracks held arrow keys.
// PARAMETERS
// - SYNC_STAGES     2      flip-flop stages on PS2_CLK and PS2_DAT (min 2)
// - TIMEOUT_CYCLES  50000  clk cycles with no PS2_CLK fall mid-frame before abort (1 ms @ 50 MHz)
// PORTS
// - clk            in   1  system clock; only clock in the block
// - rst            in   1  asynchronous, active-high reset
// - PS2_CLK        in   1  keyboard clock pin, asynchronous to clk
// - PS2_DAT        in   1  keyboard data pin, asynchronous to clk
// - scan_code      out  8  final byte of the last completed key event
// - scan_extended  out  1  event was preceded by E0
// - scan_break     out  1  event was preceded by F0 (key release)
// - scan_valid     out  1  1-cycle pulse; scan_code/extended/break valid this cycle, held until next pulse
// - frame_error    out  1  1-cycle pulse on parity, stop or timeout error
// - dir_left/dir_right/dir_up/dir_down  out  1 each  held arrow-key levels (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, bit counter 0, timeout counter 0, both prefix flags 0.
// - Reset mid-frame discards the partial frame; no pulse is emitted for it.
// - Edge detect: fall = registered previous synced PS2_CLK is 1 and current synced PS2_CLK is 0.
// - PS2_DAT sampled (synced) in the same cycle the fall is detected.
// - FSM, advancing only on a fall:
//   IDLE   : DAT=0 -> DATA with bit count 0; DAT=1 -> stay (glitch, no error).
//   DATA   : shift in LSB first; after 8th bit -> PARITY.
//   PARITY : capture bit -> STOP.
//   STOP   : if DAT=1 and XOR of the 8 data bits and parity = 1 (odd parity), the byte is good;
//            otherwise frame_error pulses. Either way -> IDLE.
// - Good byte handling, applied in the cycle after the stop-bit fall is detected:
//   E0 -> set ext_pending, no pulse.
//   F0 -> set brk_pending, no pulse.
//   other -> scan_valid=1 and scan_code=byte.
//            scan_extended=ext_pending, scan_break=brk_pending; then clear both flags.
// - Prefix order E0,F0 and F0,E0 both give ext=1, brk=1; repeated prefixes are idempotent.
// - E1 and all other bytes are emitted as ordinary codes.
// - Latency: stop-bit pin fall -> scan_valid high after SYNC_STAGES+2 clk cycles.
// - frame_error clears ext_pending and brk_pending; scan_* registers are unchanged.
// - Timeout: counter clears on every fall and holds at 0 in IDLE.
//   In DATA/PARITY/STOP, counter reaching TIMEOUT_CYCLES-1 -> frame_error pulse, prefixes cleared, IDLE.
// - Timeout takes priority over a fall arriving in the same cycle.
// - scan_valid and frame_error are never high in the same cycle.
// CONFIGURATION
// - Macro PS2_ARROW_HOLD_EN defined:
//   On scan_valid with scan_extended=1, codes 6B/74/75/72 set dir_left/dir_right/dir_up/dir_down
//   to !scan_break (take effect one cycle after scan_valid).
//   Other codes and frame errors leave the dir_* outputs unchanged.
//   Multiple directions may be high at once.
// - Macro PS2_ARROW_HOLD_EN undefined: dir_* are constant 0 and no hold registers are generated.
//   Ports remain present.
// TESTING
// - Frame 0x1C (start 0, data LSB-first, parity 0, stop 1) -> one scan_valid; code=1C, ext=0, brk=0.
// - Frames E0,75 then E0,F0,75 -> two pulses: (75,1,0) then (75,1,1).
//   With PS2_ARROW_HOLD_EN, dir_up rises and then falls.
// - Frame 0x1C sent with parity 1 -> frame_error pulse, no scan_valid; next good 0x1D -> (1D,0,0).
// - F0 sent, then frame with stop=0 -> frame_error; then 0x1C -> brk=0 (prefix cleared).
// - Stop PS2_CLK after 5 data bits -> frame_error exactly TIMEOUT_CYCLES after last fall.
//   Next full 0x29 frame -> (29,0,0).
// - Assert rst during bit 4 of a frame, release, then send 0x1C.
//   All outputs 0 during reset; no pulse for the aborted frame; then (1C,0,0).

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scan-code receiver: pin sync, 11-bit deframing, E0/F0 folding.
// Optional held-arrow tracking is enabled by defining PS2_ARROW_HOLD_EN.
module ps2_scancode_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] scan_code,
  output logic       scan_extended,
  output logic       scan_break,
  output logic       scan_valid,
  output logic       frame_error,
  output logic       dir_left,
  output logic       dir_right,
  output logic       dir_up,
  output logic       dir_down
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        byte_ok_q, byte_ok_d;
  logic        byte_bad_q, byte_bad_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [7:0]  code_q, code_d;
  logic        sext_q, sext_d;
  logic        sbrk_q, sbrk_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  logic ps2_clk_s;
  logic ps2_dat_s;
  logic fall;
  logic timeout;

  assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
  assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall      = clk_prev_q & ~ps2_clk_s;
  assign timeout   = (state_q != S_IDLE) &&
                     (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Next-state: sync chain, deframing FSM, timeout and prefix folding.
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
    clk_prev_d = ps2_clk_s;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    byte_ok_d  = 1'b0;
    byte_bad_d = 1'b0;
    ext_d      = ext_q;
    brk_d      = brk_q;
    code_d     = code_q;
    sext_d     = sext_q;
    sbrk_d     = sbrk_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    if (state_q == S_IDLE || fall) tmo_d = '0;
    else                           tmo_d = tmo_q + TW'(1);

    // Stage two: act on the byte judged one cycle earlier.
    if (byte_ok_q) begin
      unique case (shift_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        default: begin
          valid_d = 1'b1;
          code_d  = shift_q;
          sext_d  = ext_q;
          sbrk_d  = brk_q;
          ext_d   = 1'b0;
          brk_d   = 1'b0;
        end
      endcase
    end
    if (byte_bad_q) begin
      ferr_d = 1'b1;
      ext_d  = 1'b0;
      brk_d  = 1'b0;
    end

    // Timeout wins over a fall landing in the same cycle.
    if (timeout) begin
      state_d = S_IDLE;
      tmo_d   = '0;
      ferr_d  = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else if (fall) begin
      unique case (state_q)
        S_IDLE: begin
          if (!ps2_dat_s) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d   = {ps2_dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = ps2_dat_s;
          state_d  = S_STOP;
        end
        S_STOP: begin
          if (ps2_dat_s && (^{shift_q, parity_q}))
            byte_ok_d = 1'b1;
          else
            byte_bad_d = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers; sync chain idles high so reset causes no fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      byte_ok_q  <= 1'b0;
      byte_bad_q <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      code_q     <= 8'h00;
      sext_q     <= 1'b0;
      sbrk_q     <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      byte_ok_q  <= byte_ok_d;
      byte_bad_q <= byte_bad_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      code_q     <= code_d;
      sext_q     <= sext_d;
      sbrk_q     <= sbrk_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign scan_code     = code_q;
  assign scan_extended = sext_q;
  assign scan_break    = sbrk_q;
  assign scan_valid    = valid_q;
  assign frame_error   = ferr_q;

`ifdef PS2_ARROW_HOLD_EN
  // dir bit order: 0 left, 1 right, 2 up, 3 down.
  logic [3:0] dir_q, dir_d;

  // Extended arrow codes press (make) or release (break) a direction.
  always_comb begin
    dir_d = dir_q;
    if (valid_q && sext_q) begin
      unique case (code_q)
        8'h6B:   dir_d[0] = ~sbrk_q;
        8'h74:   dir_d[1] = ~sbrk_q;
        8'h75:   dir_d[2] = ~sbrk_q;
        8'h72:   dir_d[3] = ~sbrk_q;
        default: dir_d    = dir_q;
      endcase
    end
  end

  // Held-direction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir_q <= 4'b0000;
    else     dir_q <= dir_d;
  end

  assign dir_left  = dir_q[0];
  assign dir_right = dir_q[1];
  assign dir_up    = dir_q[2];
  assign dir_down  = dir_q[3];
`else
  assign dir_left  = 1'b0;
  assign dir_right = 1'b0;
  assign dir_up    = 1'b0;
  assign dir_down  = 1'b0;
`endif

endmodule
